// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: sequential fetch FSM feeding a circular instruction buffer, with epoch-tagged flush/redirect.
// Optional same-cycle response bypass to the head outputs when INST_QUEUE_BYPASS_EN is defined.
module inst_prefetch_queue #(
  parameter int QUEUE_LENGTH = 8,
  parameter int FETCH_WORDS  = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [31:0]                       pc_in,
  input  logic                              mdfy_pc,
  output logic [31:0]                       inst_out,
  output logic [31:0]                       inst_addr,
  output logic                              inst_pres,
  input  logic                              rq_nxt_inst,
  output logic                              fetch_req,
  output logic [31:0]                       fetch_addr,
  input  logic                              fetch_ack,
  input  logic                              fetch_rsp_vld,
  input  logic [32*FETCH_WORDS-1:0]         fetch_rsp_data,
  output logic [$clog2(QUEUE_LENGTH):0]     queue_count
);

  localparam int PW = $clog2(QUEUE_LENGTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] BLOCK_BYTES = 32'(FETCH_WORDS * 4);
  localparam logic [31:0] ALIGN_MASK  = ~(BLOCK_BYTES - 32'd1);
  localparam logic [CW:0] MAX_FILL    = (CW+1)'(QUEUE_LENGTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]    state;
  logic [31:0]   fetch_ptr;
  logic [31:0]   drop_pc;
  logic          drop_armed;
  logic          epoch;
  logic          req_epoch;

  logic [31:0]   q_data [QUEUE_LENGTH];
  logic [31:0]   q_addr [QUEUE_LENGTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic                   push_ok;
  logic                   q_pop;
  logic                   keep;
  logic [31:0]            word_addr;
  logic [FETCH_WORDS-1:0] wr_en;
  logic [PW-1:0]          wr_idx [FETCH_WORDS];
  logic [CW-1:0]          push_n;
  logic [CW-1:0]          free_slots;
  logic [CW:0]            next_fill;
  logic                   byp_vld;
  logic [31:0]            byp_data;
  logic [31:0]            byp_addr;

  assign free_slots = CW'(QUEUE_LENGTH) - count;
  assign next_fill  = {1'b0, count} + {1'b0, push_n};

  // Surviving response words are packed contiguously from the tail; dropped
  // words (below a redirect target) and a bypass-consumed word take no slot.
  always_comb begin
    push_ok   = rst && (state == WAIT) && fetch_rsp_vld && (req_epoch == epoch) && !mdfy_pc;
    q_pop     = (count != '0) && rq_nxt_inst && !mdfy_pc;
    wr_en     = '0;
    push_n    = '0;
    keep      = 1'b0;
    word_addr = '0;
    byp_vld   = 1'b0;
    byp_data  = '0;
    byp_addr  = '0;
    for (int i = 0; i < FETCH_WORDS; i++) begin
      wr_idx[i] = '0;
    end
    for (int i = 0; i < FETCH_WORDS; i++) begin
      word_addr = fetch_addr + 32'(4 * i);
      keep      = push_ok && (!drop_armed || (word_addr >= drop_pc));
`ifdef INST_QUEUE_BYPASS_EN
      if (keep && !byp_vld && (count == '0)) begin
        byp_vld  = 1'b1;
        byp_data = fetch_rsp_data[32*i +: 32];
        byp_addr = word_addr;
        if (rq_nxt_inst) keep = 1'b0;
      end
`endif
      if (keep) begin
        wr_en[i]  = 1'b1;
        wr_idx[i] = tail + PW'(push_n);
        push_n    = push_n + CW'(1);
      end
    end
  end

  assign inst_pres   = (count != '0) || byp_vld;
  assign inst_out    = (count != '0) ? q_data[head] : byp_data;
  assign inst_addr   = (count != '0) ? q_addr[head] : byp_addr;
  assign queue_count = count;

  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WORDS; i++) begin
      if (wr_en[i]) begin
        q_data[wr_idx[i]] <= fetch_rsp_data[32*i +: 32];
        q_addr[wr_idx[i]] <= fetch_addr + 32'(4 * i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (mdfy_pc) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + PW'(push_n);
      if (q_pop) head <= head + PW'(1);
      count <= count + push_n - CW'(q_pop);
    end
  end

  // The epoch is tagged when the request is issued, so a redirect at any point
  // before the response arrives marks that response stale.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      fetch_req  <= 1'b0;
      fetch_addr <= '0;
      fetch_ptr  <= '0;
      drop_pc    <= '0;
      drop_armed <= 1'b0;
      epoch      <= 1'b0;
      req_epoch  <= 1'b0;
    end else begin
      if (mdfy_pc) begin
        epoch      <= ~epoch;
        fetch_ptr  <= pc_in & ALIGN_MASK;
        drop_pc    <= {pc_in[31:2], 2'b00};
        drop_armed <= 1'b1;
      end else if (push_ok) begin
        fetch_ptr  <= fetch_ptr + BLOCK_BYTES;
        drop_armed <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (!mdfy_pc && (free_slots >= CW'(FETCH_WORDS))) begin
            state      <= REQ;
            fetch_req  <= 1'b1;
            fetch_addr <= fetch_ptr;
            req_epoch  <= epoch;
          end
        end
        REQ: begin
          if (fetch_ack) begin
            state     <= WAIT;
            fetch_req <= 1'b0;
          end
        end
        WAIT: begin
          if (fetch_rsp_vld) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (!rst) next_fill <= MAX_FILL);

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed table-driven bench for inst_prefetch_queue; the bypass sequence runs only when INST_QUEUE_BYPASS_EN is defined.
module tb_inst_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        mdfy_pc;
  logic [31:0] inst_out;
  logic [31:0] inst_addr;
  logic        inst_pres;
  logic        rq_nxt_inst;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ack;
  logic        fetch_rsp_vld;
  logic [63:0] fetch_rsp_data;
  logic [3:0]  queue_count;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic        r;
    logic        m;
    logic [31:0] pc;
    logic        rq;
    logic        ack;
    logic        vld;
    logic [63:0] data;
    logic        ereq;
    logic [31:0] efa;
    logic        epres;
    logic [31:0] eout;
    logic [31:0] eia;
    logic [3:0]  ecnt;
  } vec_t;

  vec_t vecs[$];

  inst_prefetch_queue #(.QUEUE_LENGTH(8), .FETCH_WORDS(2)) dut (
    .clk(clk),
    .rst(rst),
    .pc_in(pc_in),
    .mdfy_pc(mdfy_pc),
    .inst_out(inst_out),
    .inst_addr(inst_addr),
    .inst_pres(inst_pres),
    .rq_nxt_inst(rq_nxt_inst),
    .fetch_req(fetch_req),
    .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack),
    .fetch_rsp_vld(fetch_rsp_vld),
    .fetch_rsp_data(fetch_rsp_data),
    .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, m, input logic [31:0] pc, input logic rq, ack, vld,
                              input logic [63:0] data, input logic ereq, input logic [31:0] efa,
                              input logic epres, input logic [31:0] eout, eia, input logic [3:0] ecnt);
    vec_t v;
    v.r = r; v.m = m; v.pc = pc; v.rq = rq; v.ack = ack; v.vld = vld; v.data = data;
    v.ereq = ereq; v.efa = efa; v.epres = epres; v.eout = eout; v.eia = eia; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic applyStimulus(input logic r, m, input logic [31:0] pc, input logic rq, ack, vld,
                               input logic [63:0] data);
    rst = r; mdfy_pc = m; pc_in = pc; rq_nxt_inst = rq;
    fetch_ack = ack; fetch_rsp_vld = vld; fetch_rsp_data = data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic ereq, input logic [31:0] efa,
                             input logic epres, input logic [31:0] eout, eia, input logic [3:0] ecnt);
    compared++;
    if ({fetch_req, fetch_addr, inst_pres, inst_out, inst_addr, queue_count} !==
        {ereq, efa, epres, eout, eia, ecnt}) begin
      mismatched++;
      $display("[TB] FAIL %s: got req=%0b faddr=%h pres=%0b inst=%h iaddr=%h count=%0d, expected req=%0b faddr=%h pres=%0b inst=%h iaddr=%h count=%0d",
               name, fetch_req, fetch_addr, inst_pres, inst_out, inst_addr, queue_count,
               ereq, efa, epres, eout, eia, ecnt);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //                r  m  pc          rq ack vld data                   req faddr        pres inst         iaddr        cnt
    vecs.push_back(mk(0, 0, 32'h0,      0, 0, 0, 64'h0,                  0, 32'h0,      0, 32'h0,        32'h0,       4'd0));
    vecs.push_back(mk(1, 0, 32'h0,      0, 0, 0, 64'h0,                  1, 32'h0,      0, 32'h0,        32'h0,       4'd0));
    vecs.push_back(mk(1, 0, 32'h0,      0, 1, 0, 64'h0,                  0, 32'h0,      0, 32'h0,        32'h0,       4'd0));
    vecs.push_back(mk(1, 0, 32'h0,      0, 0, 1, 64'h22222222_11111111,  0, 32'h0,      1, 32'h11111111, 32'h0,       4'd2));
    vecs.push_back(mk(1, 0, 32'h0,      1, 0, 0, 64'h0,                  1, 32'h8,      1, 32'h22222222, 32'h4,       4'd1));
    vecs.push_back(mk(1, 0, 32'h0,      0, 1, 0, 64'h0,                  0, 32'h8,      1, 32'h22222222, 32'h4,       4'd1));
    vecs.push_back(mk(1, 0, 32'h0,      0, 0, 1, 64'h44444444_33333333,  0, 32'h8,      1, 32'h22222222, 32'h4,       4'd3));
    vecs.push_back(mk(1, 0, 32'h0,      1, 0, 0, 64'h0,                  1, 32'h10,     1, 32'h33333333, 32'h8,       4'd2));
    vecs.push_back(mk(1, 0, 32'h0,      0, 1, 0, 64'h0,                  0, 32'h10,     1, 32'h33333333, 32'h8,       4'd2));
    vecs.push_back(mk(1, 0, 32'h0,      0, 0, 1, 64'h66666666_55555555,  0, 32'h10,     1, 32'h33333333, 32'h8,       4'd4));
    vecs.push_back(mk(1, 0, 32'h0,      0, 0, 0, 64'h0,                  1, 32'h18,     1, 32'h33333333, 32'h8,       4'd4));
    vecs.push_back(mk(1, 0, 32'h0,      0, 1, 0, 64'h0,                  0, 32'h18,     1, 32'h33333333, 32'h8,       4'd4));
    vecs.push_back(mk(1, 0, 32'h0,      0, 0, 1, 64'h88888888_77777777,  0, 32'h18,     1, 32'h33333333, 32'h8,       4'd6));
    vecs.push_back(mk(1, 0, 32'h0,      0, 0, 0, 64'h0,                  1, 32'h20,     1, 32'h33333333, 32'h8,       4'd6));
    vecs.push_back(mk(1, 0, 32'h0,      0, 1, 0, 64'h0,                  0, 32'h20,     1, 32'h33333333, 32'h8,       4'd6));
    vecs.push_back(mk(1, 0, 32'h0,      0, 0, 1, 64'hAAAAAAAA_99999999,  0, 32'h20,     1, 32'h33333333, 32'h8,       4'd8));
    vecs.push_back(mk(1, 0, 32'h0,      0, 0, 0, 64'h0,                  0, 32'h20,     1, 32'h33333333, 32'h8,       4'd8));
    vecs.push_back(mk(1, 0, 32'h0,      0, 0, 0, 64'h0,                  0, 32'h20,     1, 32'h33333333, 32'h8,       4'd8));
    vecs.push_back(mk(1, 0, 32'h0,      1, 0, 0, 64'h0,                  0, 32'h20,     1, 32'h44444444, 32'hC,       4'd7));
    vecs.push_back(mk(1, 0, 32'h0,      0, 0, 0, 64'h0,                  0, 32'h20,     1, 32'h44444444, 32'hC,       4'd7));
    vecs.push_back(mk(1, 0, 32'h0,      1, 0, 0, 64'h0,                  0, 32'h20,     1, 32'h55555555, 32'h10,      4'd6));
    vecs.push_back(mk(1, 0, 32'h0,      0, 0, 0, 64'h0,                  1, 32'h28,     1, 32'h55555555, 32'h10,      4'd6));
    vecs.push_back(mk(1, 0, 32'h0,      1, 1, 0, 64'h0,                  0, 32'h28,     1, 32'h66666666, 32'h14,      4'd5));
    vecs.push_back(mk(1, 0, 32'h0,      1, 0, 1, 64'hCCCCCCCC_BBBBBBBB,  0, 32'h28,     1, 32'h77777777, 32'h18,      4'd6));
    vecs.push_back(mk(1, 0, 32'h0,      1, 0, 0, 64'h0,                  1, 32'h30,     1, 32'h88888888, 32'h1C,      4'd5));
    vecs.push_back(mk(1, 0, 32'h0,      1, 0, 0, 64'h0,                  1, 32'h30,     1, 32'h99999999, 32'h20,      4'd4));
    vecs.push_back(mk(1, 0, 32'h0,      1, 0, 0, 64'h0,                  1, 32'h30,     1, 32'hAAAAAAAA, 32'h24,      4'd3));
    vecs.push_back(mk(1, 0, 32'h0,      0, 1, 0, 64'h0,                  0, 32'h30,     1, 32'hAAAAAAAA, 32'h24,      4'd3));
    vecs.push_back(mk(1, 0, 32'h0,      1, 0, 1, 64'hEEEEEEEE_DDDDDDDD,  0, 32'h30,     1, 32'hBBBBBBBB, 32'h28,      4'd4));
    vecs.push_back(mk(1, 0, 32'h0,      1, 0, 0, 64'h0,                  1, 32'h38,     1, 32'hCCCCCCCC, 32'h2C,      4'd3));
    vecs.push_back(mk(1, 1, 32'h104,    1, 0, 0, 64'h0,                  1, 32'h38,     0, 32'h0,        32'h0,       4'd0));
    vecs.push_back(mk(1, 0, 32'h0,      0, 0, 0, 64'h0,                  1, 32'h38,     0, 32'h0,        32'h0,       4'd0));
    vecs.push_back(mk(1, 0, 32'h0,      0, 1, 0, 64'h0,                  0, 32'h38,     0, 32'h0,        32'h0,       4'd0));
    vecs.push_back(mk(1, 0, 32'h0,      0, 0, 1, 64'hDEAD0004_DEAD0000,  0, 32'h38,     0, 32'h0,        32'h0,       4'd0));
    vecs.push_back(mk(1, 0, 32'h0,      0, 0, 0, 64'h0,                  1, 32'h100,    0, 32'h0,        32'h0,       4'd0));
    vecs.push_back(mk(1, 0, 32'h0,      0, 1, 0, 64'h0,                  0, 32'h100,    0, 32'h0,        32'h0,       4'd0));
    vecs.push_back(mk(1, 0, 32'h0,      0, 0, 1, 64'h11110104_11110100,  0, 32'h100,    1, 32'h11110104, 32'h104,     4'd1));
    vecs.push_back(mk(1, 0, 32'h0,      0, 0, 0, 64'h0,                  1, 32'h108,    1, 32'h11110104, 32'h104,     4'd1));
    vecs.push_back(mk(1, 0, 32'h0,      0, 1, 0, 64'h0,                  0, 32'h108,    1, 32'h11110104, 32'h104,     4'd1));
    vecs.push_back(mk(0, 0, 32'h0,      0, 0, 1, 64'h5A5A5A5A_A5A5A5A5,  0, 32'h0,      0, 32'h0,        32'h0,       4'd0));
    vecs.push_back(mk(1, 0, 32'h0,      0, 0, 1, 64'h5A5A5A5A_A5A5A5A5,  1, 32'h0,      0, 32'h0,        32'h0,       4'd0));
    vecs.push_back(mk(1, 0, 32'h0,      0, 1, 0, 64'h0,                  0, 32'h0,      0, 32'h0,        32'h0,       4'd0));
    vecs.push_back(mk(1, 0, 32'h0,      0, 0, 1, 64'h00000002_00000001,  0, 32'h0,      1, 32'h1,        32'h0,       4'd2));

    applyStimulus(0, 0, 32'h0, 0, 0, 0, 64'h0);
    #2;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].r, vecs[i].m, vecs[i].pc, vecs[i].rq, vecs[i].ack, vecs[i].vld, vecs[i].data);
      tick();
      checkOutput($sformatf("vec%0d", i), vecs[i].ereq, vecs[i].efa, vecs[i].epres,
                  vecs[i].eout, vecs[i].eia, vecs[i].ecnt);
    end

    // Response landing in the same cycle as a redirect is discarded.
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 64'h0);
    tick();
    checkOutput("redir_req", 1, 32'h8, 1, 32'h1, 32'h0, 4'd2);
    applyStimulus(1, 0, 32'h0, 0, 1, 0, 64'h0);
    tick();
    checkOutput("redir_ack", 0, 32'h8, 1, 32'h1, 32'h0, 4'd2);
    applyStimulus(1, 1, 32'h200, 0, 0, 1, 64'h00000004_00000003);
    tick();
    checkOutput("redir_rsp_drop", 0, 32'h8, 0, 32'h0, 32'h0, 4'd0);
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 64'h0);
    tick();
    checkOutput("redir_new_req", 1, 32'h200, 0, 32'h0, 32'h0, 4'd0);
    applyStimulus(1, 0, 32'h0, 0, 1, 0, 64'h0);
    tick();
    checkOutput("redir_new_ack", 0, 32'h200, 0, 32'h0, 32'h0, 4'd0);
    applyStimulus(1, 0, 32'h0, 0, 0, 1, 64'h0000000B_0000000A);
    tick();
    checkOutput("redir_new_rsp", 0, 32'h200, 1, 32'hA, 32'h200, 4'd2);

`ifdef INST_QUEUE_BYPASS_EN
    applyStimulus(1, 1, 32'h300, 0, 0, 0, 64'h0);
    tick();
    checkOutput("byp_flush", 0, 32'h200, 0, 32'h0, 32'h0, 4'd0);
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 64'h0);
    tick();
    checkOutput("byp_req", 1, 32'h300, 0, 32'h0, 32'h0, 4'd0);
    applyStimulus(1, 0, 32'h0, 0, 1, 0, 64'h0);
    tick();
    checkOutput("byp_ack", 0, 32'h300, 0, 32'h0, 32'h0, 4'd0);
    applyStimulus(1, 0, 32'h0, 1, 0, 1, 64'h0000000D_0000000C);
    #1;
    checkOutput("byp_same_cycle", 0, 32'h300, 1, 32'hC, 32'h300, 4'd0);
    tick();
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 64'h0);
    #1;
    checkOutput("byp_after", 0, 32'h300, 1, 32'hD, 32'h304, 4'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
